dbus_serializer: RTL
====================

DBUS_SERIALIZER -- requirements
Module: dbus_serializer

Interface
REQ-001 The block SHALL have no parameters; widths are fixed by dbus_req_t/dbus_resp_t (addr 32, data 32, strobe 4, size 3).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 dreq_in  input  2 x dbus_req_t  memory-stage requests; slot [1] is the older instruction, slot [0] the younger.
REQ-005 kill0  input  1  suppress slot 0 (older slot excepting/ERET); sampled only in IDLE.
REQ-006 flush  input  1  pipeline flush; abandon all not-yet-accepted requests.
REQ-007 dreq  output  dbus_req_t  single request port to data cache.
REQ-008 dresp  input  dbus_resp_t  cache response: addr_ok, data_ok, data[31:0].
REQ-009 rdata  output  2 x 32  captured load data per slot.
REQ-010 stall  output  1  holds memory stage (and upstream) while requests are pending.
REQ-011 done  output  1  one-cycle pulse: all requests of current pair completed.

Function
REQ-012 States SHALL be IDLE, ISSUE, WAIT, DONE; a 1-bit cur register selects the slot being served; a 2-bit pend register marks slots still to serve.
REQ-013 IDLE: pend_next = {dreq_in[1].valid, dreq_in[0].valid & ~kill0}; if pend_next != 0 and flush = 0 -> ISSUE with cur = 1 if pend_next[1] else 0; otherwise stay IDLE.
REQ-014 ISSUE: dreq SHALL equal the latched copy of dreq_in[cur] with valid = 1; dreq SHALL stay bit-stable until addr_ok.
REQ-015 ISSUE with addr_ok = 1 and data_ok = 0 -> WAIT; with addr_ok = 1 and data_ok = 1 same cycle -> capture and advance per REQ-017.
REQ-016 WAIT: dreq.valid = 0; on data_ok capture and advance per REQ-017.
REQ-017 Capture/advance: rdata[cur] <= dresp.data (also for stores, value don't-care); clear pend[cur]; if remaining pend != 0 and no flush seen -> ISSUE with cur = 0, else -> DONE.
REQ-018 Only one request outstanding at any time; slot 1 SHALL always be issued before slot 0.
REQ-019 Both slots' request fields SHALL be latched on the IDLE -> ISSUE edge; later dreq_in changes SHALL be ignored until the next IDLE.
REQ-020 flush in ISSUE before addr_ok -> drop request, go to DONE next cycle; flush after addr_ok (WAIT, or ISSUE same cycle as addr_ok) -> record flush, finish data_ok, skip remaining slot, go to DONE.
REQ-021 DONE: done = 1, stall = 0 for exactly one cycle, then IDLE.
REQ-022 stall = 1 in ISSUE and WAIT, and in IDLE whenever pend_next != 0 and flush = 0; stall = 0 otherwise.
REQ-023 A slot with valid = 0 (or killed) SHALL never be issued and its rdata SHALL keep its previous value.
REQ-024 Minimum latency: single request with addr_ok & data_ok in first ISSUE cycle -> stall high 2 cycles, done on 3rd cycle; two such requests -> stall 3 cycles, done on 4th.
REQ-025 dreq.valid SHALL never be asserted in IDLE, WAIT or DONE.

Reset
REQ-026 resetn = 0 SHALL immediately force IDLE, pend = 0, cur = 0, rdata = 0, done = 0, stall = 0, dreq = all-zero, regardless of state.
REQ-027 Reset mid-transaction SHALL discard the outstanding request; any data_ok arriving after release while in IDLE SHALL be ignored.

Verification
REQ-028 Load slot1 addr 0x8000_0010, slot0 invalid, addr_ok+data_ok in first ISSUE, data 0xDEAD_BEEF -> one dreq valid cycle, rdata[1] = 0xDEAD_BEEF, done on cycle 3.
REQ-029 Both slots valid (load 0x100, store 0x104 strobe 4'b1111 data 0x1234_5678), addr_ok delayed 2 cycles each, data_ok 1 cycle after -> slot 1 issued first, dreq stable during wait, 0x104 issued only after slot 1 data_ok, single done pulse.
REQ-030 Both valid with kill0 = 1 in IDLE -> only slot 1 issued, rdata[0] unchanged.
REQ-031 flush in WAIT for slot 1 with slot 0 pending -> data_ok accepted, slot 0 never issued, DONE next, stall low.
REQ-032 flush in ISSUE with addr_ok = 0 -> dreq.valid drops next cycle, DONE then IDLE, no further requests.
REQ-033 resetn asserted in WAIT -> all outputs zero immediately; stray data_ok after release causes no state change.

Source files
------------

// File: rtl/dbus_serializer.sv
// Serializes a dual-issue memory-stage request pair onto a single data-cache port.
// Slot 1 (older) is always served before slot 0, and only one request is outstanding at a time.

package dbus_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 3;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;
endpackage

module dbus_serializer
  import dbus_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  dbus_req_t [1:0]        dreq_in,
  input  logic                   kill0,
  input  logic                   flush,
  output dbus_req_t              dreq,
  input  dbus_resp_t             dresp,
  output logic [1:0][DATA_W-1:0] rdata,
  output logic                   stall,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_n;
  logic            cur, cur_n;
  logic [1:0]      pend, pend_n;
  logic            flushed, flushed_n;
  logic            latch_en, cap_en;
  logic [1:0]      pend_in;
  logic [1:0]      pend_rem;
  logic            flush_seen;
  dbus_req_t [1:0] lat;
  dbus_req_t       req_sel;

  assign pend_in    = {dreq_in[1].valid, dreq_in[0].valid & ~kill0};
  assign pend_rem   = pend & ~(2'b01 << cur);
  assign flush_seen = flushed | flush;

  // Next-state, handshake and status decode
  always_comb begin
    state_n       = state;
    cur_n         = cur;
    pend_n        = pend;
    flushed_n     = flushed;
    latch_en      = 1'b0;
    cap_en        = 1'b0;
    stall         = 1'b0;
    done          = 1'b0;
    dreq          = '0;
    req_sel       = lat[cur];
    req_sel.valid = 1'b1;

    case (state)
      IDLE: begin
        if ((|pend_in) && !flush) begin
          stall     = resetn;
          latch_en  = 1'b1;
          pend_n    = pend_in;
          cur_n     = pend_in[1];
          flushed_n = 1'b0;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        stall = 1'b1;
        dreq  = req_sel;
        if (dresp.addr_ok) begin
          if (dresp.data_ok) begin
            cap_en = 1'b1;
            pend_n = pend_rem;
            if ((|pend_rem) && !flush_seen) begin
              cur_n   = 1'b0;
              state_n = ISSUE;
            end else begin
              state_n = DONE;
            end
          end else begin
            flushed_n = flush;
            state_n   = WAIT;
          end
        end else if (flush) begin
          // Not yet accepted by the cache, so the request can simply be dropped
          pend_n  = '0;
          state_n = DONE;
        end
      end
      WAIT: begin
        stall     = 1'b1;
        flushed_n = flush_seen;
        if (dresp.data_ok) begin
          cap_en = 1'b1;
          pend_n = pend_rem;
          if ((|pend_rem) && !flush_seen) begin
            cur_n   = 1'b0;
            state_n = ISSUE;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        pend_n    = '0;
        flushed_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cur     <= 1'b0;
      pend    <= '0;
      flushed <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      pend    <= pend_n;
      flushed <= flushed_n;
    end
  end

  // Request snapshot and per-slot load data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat   <= '0;
      rdata <= '0;
    end else begin
      if (latch_en) lat <= dreq_in;
      if (cap_en) rdata[cur] <= dresp.data;
    end
  end

endmodule
